// File: rtl/decoder_dram_rreq_fsm_if.sv
// DRAM read-request side of the stego-frame reader: request, address,
// master-idle and read-beat strobes.
interface decoder_dram_rreq_fsm_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] dram_raddr;
  logic                  dram_rreq;
  logic                  axi_m_can_accept_rreq;
  logic                  rnext;

  modport master (
    output dram_raddr,
    output dram_rreq,
    input  axi_m_can_accept_rreq,
    input  rnext
  );

  modport slave (
    input  dram_raddr,
    input  dram_rreq,
    output axi_m_can_accept_rreq,
    output rnext
  );
endinterface

// File: rtl/decoder_dram_rreq_fsm.sv
// Queues stego frame base addresses and walks each frame as DRAM bursts.
// Define DECODER_RREQ_ABORT_EN to add the abort_decoding input.
module decoder_dram_rreq_fsm #(
  parameter int ADDR_WIDTH         = 32,
  parameter int DATA_WIDTH         = 32,
  parameter int IMG_RBURST_LEN     = 128,
  parameter int NUM_RREQS_PER_SIMG = 7200,
  parameter int BADDR_QUEUE_DEPTH  = 4
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic [ADDR_WIDTH-1:0] simg_baddr,
  input  logic                  begin_decoding,
  input  logic                  simg_infifo_has_space,
`ifdef DECODER_RREQ_ABORT_EN
  input  logic                  abort_decoding,
`endif
  decoder_dram_rreq_fsm_if.master dram,
  output logic                  simg_infifo_wr_en,
  output logic                  baddr_queue_full,
  output logic                  done_decoding
);

  localparam int BEAT_W  = $clog2(IMG_RBURST_LEN + 1);
  localparam int BURST_W = $clog2(NUM_RREQS_PER_SIMG + 1);
  localparam int CNT_W   = $clog2(BADDR_QUEUE_DEPTH + 1);
  localparam int PTR_W   =
    (BADDR_QUEUE_DEPTH > 1) ? $clog2(BADDR_QUEUE_DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] STRIDE =
    ADDR_WIDTH'(IMG_RBURST_LEN * DATA_WIDTH / 8);
  localparam logic [BEAT_W-1:0] BEAT_LAST =
    BEAT_W'(IMG_RBURST_LEN - 1);
  localparam logic [BURST_W-1:0] BURST_MAX =
    BURST_W'(NUM_RREQS_PER_SIMG);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
  localparam logic [CNT_W-1:0] Q_DEPTH =
    CNT_W'(BADDR_QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST =
    PTR_W'(BADDR_QUEUE_DEPTH - 1);

  typedef enum logic [2:0] {
    RREQ_IDLE,
    GET_SIMG_BADDR,
    START_READ_SIMG,
    READ_SIMG,
    RREQ_DECIDE_NEXT
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] q_mem [BADDR_QUEUE_DEPTH];
  logic [PTR_W-1:0]      q_rd, q_wr;
  logic [CNT_W-1:0]      q_cnt;
  logic                  q_empty, push, pop;

  logic [ADDR_WIDTH-1:0] pend_addr, simg_addr;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [BURST_W-1:0]    burst_cnt;
  logic                  last_beat, frame_end;

  // kill: abort seen this cycle; quit: burst in flight must end in idle
  logic kill, quit;
`ifdef DECODER_RREQ_ABORT_EN
  logic abort_pend;

  always_ff @(posedge axi_clk) begin
    if (axi_reset)
      abort_pend <= 1'b0;
    else if (state != READ_SIMG)
      abort_pend <= 1'b0;
    else if (abort_decoding)
      abort_pend <= 1'b1;
  end

  assign kill = abort_decoding;
  assign quit = abort_decoding | abort_pend;
`else
  assign kill = 1'b0;
  assign quit = 1'b0;
`endif

  assign q_empty          = (q_cnt == '0);
  assign baddr_queue_full = (q_cnt == Q_DEPTH);
  assign pop  = (state == RREQ_IDLE) && !q_empty && !kill;
  assign push = begin_decoding && !kill &&
                (!baddr_queue_full || pop);

  always_ff @(posedge axi_clk) begin
    if (push)
      q_mem[q_wr] <= simg_baddr;
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset || kill) begin
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
    end else begin
      if (push)
        q_wr <= (q_wr == PTR_LAST) ? '0 : q_wr + PTR_W'(1);
      if (pop)
        q_rd <= (q_rd == PTR_LAST) ? '0 : q_rd + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   q_cnt <= q_cnt + CNT_W'(1);
        2'b01:   q_cnt <= q_cnt - CNT_W'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  assign last_beat = dram.rnext && (beat_cnt == BEAT_LAST);
  assign frame_end = (burst_cnt >= BURST_MAX);

  always_ff @(posedge axi_clk) begin
    if (axi_reset)
      state <= RREQ_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RREQ_IDLE:
        if (pop) state_nxt = GET_SIMG_BADDR;
      GET_SIMG_BADDR:
        state_nxt = START_READ_SIMG;
      START_READ_SIMG:
        if (simg_infifo_has_space && dram.axi_m_can_accept_rreq)
          state_nxt = READ_SIMG;
      READ_SIMG:
        if (last_beat)
          state_nxt = quit ? RREQ_IDLE : RREQ_DECIDE_NEXT;
      RREQ_DECIDE_NEXT:
        state_nxt = frame_end ? RREQ_IDLE : START_READ_SIMG;
      default:
        state_nxt = RREQ_IDLE;
    endcase
    if (kill && state != READ_SIMG)
      state_nxt = RREQ_IDLE;
  end

  always_comb begin
    simg_infifo_wr_en = 1'b0;
    done_decoding     = 1'b0;
    if (state == READ_SIMG)
      simg_infifo_wr_en = dram.rnext;
    if (state == RREQ_DECIDE_NEXT)
      done_decoding = frame_end && !kill;
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      pend_addr       <= '0;
      simg_addr       <= '0;
      dram.dram_raddr <= '0;
      dram.dram_rreq  <= 1'b0;
      beat_cnt        <= '0;
      burst_cnt       <= BURST_ONE;
    end else begin
      dram.dram_raddr <= simg_addr;
      dram.dram_rreq  <= (state == START_READ_SIMG) &&
                         (state_nxt == READ_SIMG);
      if (pop)
        pend_addr <= q_mem[q_rd];
      unique case (state)
        GET_SIMG_BADDR: begin
          simg_addr <= pend_addr;
          burst_cnt <= BURST_ONE;
        end
        START_READ_SIMG:
          if (state_nxt == READ_SIMG) beat_cnt <= '0;
        READ_SIMG:
          if (dram.rnext) beat_cnt <= beat_cnt + BEAT_W'(1);
        RREQ_DECIDE_NEXT:
          if (state_nxt == START_READ_SIMG) begin
            simg_addr <= simg_addr + STRIDE;
            burst_cnt <= burst_cnt + BURST_ONE;
          end
        default: ;
      endcase
      if (state_nxt == RREQ_IDLE)
        burst_cnt <= BURST_ONE;
    end
  end

endmodule

// File: tb/tb_decoder_dram_rreq_fsm.sv
// Directed + randomized bench for decoder_dram_rreq_fsm with a
// frame/burst/beat scoreboard (LEN=4, 3 bursts per frame, 32-bit beats).
module tb_decoder_dram_rreq_fsm;

  localparam int AW     = 32;
  localparam int LEN    = 4;
  localparam int NB     = 3;
  localparam int STRIDE = LEN * 32 / 8;

  logic          clk = 1'b0;
  logic          axi_reset;
  logic [AW-1:0] simg_baddr;
  logic          begin_decoding;
  logic          simg_infifo_has_space;
  logic          simg_infifo_wr_en;
  logic          baddr_queue_full;
  logic          done_decoding;
`ifdef DECODER_RREQ_ABORT_EN
  logic          abort_decoding;
`endif

  decoder_dram_rreq_fsm_if #(.ADDR_WIDTH(AW)) dram ();

  decoder_dram_rreq_fsm #(
    .ADDR_WIDTH        (AW),
    .DATA_WIDTH        (32),
    .IMG_RBURST_LEN    (LEN),
    .NUM_RREQS_PER_SIMG(NB),
    .BADDR_QUEUE_DEPTH (4)
  ) dut (
    .axi_clk              (clk),
    .axi_reset            (axi_reset),
    .simg_baddr           (simg_baddr),
    .begin_decoding       (begin_decoding),
    .simg_infifo_has_space(simg_infifo_has_space),
`ifdef DECODER_RREQ_ABORT_EN
    .abort_decoding       (abort_decoding),
`endif
    .dram                 (dram.master),
    .simg_infifo_wr_en    (simg_infifo_wr_en),
    .baddr_queue_full     (baddr_queue_full),
    .done_decoding        (done_decoding)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // directed input values, applied at each falling edge
  bit            rand_mode;
  bit            d_rst, d_begin, d_space, d_acc, d_rnext, d_abort;
  logic [AW-1:0] d_baddr;

  // reference model: expected request addresses, beats left, bursts done
  logic [AW-1:0] exp_q [$];
  int  rem, bursts;
  bit  done_due, aborting;
  int  n_rreq, n_wr, n_done;
  bit  last_rreq, last_done, last_full;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit exp_wr;
    @(negedge clk);
    axi_reset      = d_rst;
    begin_decoding = d_begin;
    simg_baddr     = d_baddr;
`ifdef DECODER_RREQ_ABORT_EN
    abort_decoding = d_abort;
`endif
    if (rand_mode) begin
      simg_infifo_has_space      = ($urandom % 4) != 0;
      dram.axi_m_can_accept_rreq = ($urandom % 3) != 0;
      dram.rnext = (rem > 0) ? 1'($urandom % 2)
                             : (($urandom % 5) == 0);
    end else begin
      simg_infifo_has_space      = d_space;
      dram.axi_m_can_accept_rreq = d_acc;
      dram.rnext                 = d_rnext;
    end
    #1;
    last_rreq = dram.dram_rreq;
    last_done = done_decoding;
    last_full = baddr_queue_full;
    if (dram.dram_rreq) begin
      n_rreq++;
      chk("rreq_mid_burst", rem, 0);
      chk("rreq_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0)
        chk("raddr", dram.dram_raddr, exp_q.pop_front());
      rem = LEN;
    end
    exp_wr = dram.rnext && (rem > 0);
    chk("wr_en", simg_infifo_wr_en, exp_wr);
    chk("done", done_decoding, done_due);
    if (simg_infifo_wr_en) n_wr++;
    if (done_decoding) n_done++;
    done_due = 1'b0;
    if (exp_wr) begin
      rem--;
      if (rem == 0) begin
        if (aborting) begin
          aborting = 1'b0;
          bursts   = 0;
        end else begin
          bursts++;
          if (bursts == NB) begin
            bursts   = 0;
            done_due = 1'b1;
          end
        end
      end
    end
    if (d_rst) begin
      exp_q.delete();
      rem      = 0;
      bursts   = 0;
      done_due = 1'b0;
      aborting = 1'b0;
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input bit accept);
    d_begin = 1'b1;
    d_baddr = a;
    step();
    d_begin = 1'b0;
    if (accept)
      for (int k = 0; k < NB; k++)
        exp_q.push_back(a + AW'(k * STRIDE));
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin
      step();
      k++;
    end
    chk("frames_done", n_done, target);
  endtask

  initial begin
    int base_wr, base_rreq, base_done, k;
    logic [AW-1:0] a;
    rand_mode = 1'b0;
    d_rst = 1'b1; d_begin = 1'b0; d_baddr = '0;
    d_space = 1'b0; d_acc = 1'b0; d_rnext = 1'b0; d_abort = 1'b0;
    rem = 0; bursts = 0; done_due = 0; aborting = 0;
    n_rreq = 0; n_wr = 0; n_done = 0;
    step();
    step();
    d_rst = 1'b0;
    step();
    chk("rst_raddr", dram.dram_raddr, 0);
    chk("rst_rreq", dram.dram_rreq, 0);
    chk("rst_full", baddr_queue_full, 0);
    chk("rst_done", done_decoding, 0);

    // one frame, every handshake held high
    d_space = 1'b1; d_acc = 1'b1; d_rnext = 1'b1;
    base_wr = n_wr; base_rreq = n_rreq;
    push(32'h1000, 1'b1);
    wait_done(1, 100);
    chk("f1_beats", n_wr - base_wr, 12);
    chk("f1_rreqs", n_rreq - base_rreq, 3);
    chk("f1_queue", exp_q.size(), 0);

    // FIFO backpressure holds the request
    d_space = 1'b0; d_rnext = 1'b0;
    base_rreq = n_rreq;
    push(32'h4000, 1'b1);
    repeat (20) step();
    chk("bp_no_rreq", n_rreq - base_rreq, 0);
    d_space = 1'b1;
    step();
    chk("bp_rreq_wait", last_rreq, 0);
    step();
    chk("bp_rreq_next", last_rreq, 1);
    rand_mode = 1'b1;
    wait_done(2, 400);

    // fill the queue behind a stalled frame, drop the fifth push
    rand_mode = 1'b0;
    d_space = 1'b0; d_acc = 1'b1; d_rnext = 1'b0;
    push(32'h5000, 1'b1);
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      push(32'h8000 + AW'(i * 256), i < 4);
      chk("full_at_push", last_full, i == 4);
    end
    step();
    chk("full_held", last_full, 1);
    d_space = 1'b1; d_rnext = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (!last_done && k < 200);
    chk("x_done", last_done, 1);
    // pop cycle: the push while full must be taken
    push(32'h9000, 1'b1);
    chk("full_at_pop", last_full, 1);
    step();
    chk("full_after_swap", last_full, 1);
    wait_done(8, 800);
    chk("q_drained", exp_q.size(), 0);

    // reset after beat 2 of burst 2
    rand_mode = 1'b1;
    push(32'h2000, 1'b1);
    k = 0;
    while (!(bursts == 1 && rem == LEN - 2) && k < 500) begin
      step();
      k++;
    end
    chk("mid_burst_reached", rem, LEN - 2);
    rand_mode = 1'b0;
    d_space = 1'b0; d_rnext = 1'b0;
    base_done = n_done;
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    step();
    chk("rr_raddr", dram.dram_raddr, 0);
    chk("rr_rreq", dram.dram_rreq, 0);
    chk("rr_wr", simg_infifo_wr_en, 0);
    chk("rr_full", baddr_queue_full, 0);
    chk("rr_no_done", n_done - base_done, 0);
    rand_mode = 1'b1;
    push(32'h3000, 1'b1);
    wait_done(n_done + 1, 600);

    // random handshakes, random bases, one frame wrapping 2^32
    for (int r = 0; r < 2; r++) begin
      base_done = n_done;
      for (int i = 0; i < 3; i++) begin
        a = (r == 0 && i == 0) ? 32'hFFFF_FFE8
                               : ($urandom & 32'hFFFF_FFFC);
        push(a, 1'b1);
      end
      wait_done(base_done + 3, 3000);
    end
    chk("rand_queue", exp_q.size(), 0);

`ifdef DECODER_RREQ_ABORT_EN
    // abort on beat 1: burst completes, then idle with queue flushed
    rand_mode = 1'b0;
    d_space = 1'b1; d_acc = 1'b1; d_rnext = 1'b0;
    push(32'h6000, 1'b1);
    push(32'h7000, 1'b1);
    k = 0;
    do begin
      step();
      k++;
    end while (!last_rreq && k < 50);
    chk("ab_rreq", last_rreq, 1);
    base_wr = n_wr; base_rreq = n_rreq; base_done = n_done;
    d_abort = 1'b1; d_rnext = 1'b1;
    step();
    d_abort = 1'b0;
    exp_q.delete();
    aborting = (rem > 0);
    if (rem == 0) bursts = 0;
    repeat (3) step();
    chk("ab_beats", n_wr - base_wr, 4);
    rand_mode = 1'b1;
    repeat (40) step();
    chk("ab_no_rreq", n_rreq - base_rreq, 0);
    chk("ab_no_done", n_done - base_done, 0);
    chk("ab_full", last_full, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
